// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Core side: combinational hit path and stall. Memory side: one registered
// single-word request at a time, held until MEM_ACK.
module dcache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MCACHE_ADR_VALID_SM,
  input  logic        MCACHE_LOAD_SM,
  input  logic        MCACHE_STORE_SM,
  input  logic [31:0] MCACHE_ADR_SM,
  input  logic [31:0] MCACHE_DATA_SM,
  input  logic [3:0]  byt_sel,
  output logic [31:0] MCACHE_RESULT_SM,
  output logic        MCACHE_STALL_SM,
  output logic [31:0] MEM_ADR,
  output logic [31:0] MEM_DATA_W,
  output logic [3:0]  MEM_BYT_SEL,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DATA_R
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - IDX;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] WR_DONE = 2'd3;

  logic [1:0]       state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             req_load;
  logic             req_store;
  logic             req_hit;
  logic             lat_hit;
  logic             fill_en;
  logic             merge_en;
  logic [31:0]      merged;
  logic             unused_adr_bits;

  // Byte offset plays no part in lookup; memory always sees a word address.
  assign unused_adr_bits = ^MCACHE_ADR_SM[1:0];

  // Lookup fields of the live request and of the latched (in-flight) one.
  // MEM_ADR doubles as the latched address for the whole transaction.
  assign req_idx = MCACHE_ADR_SM[IDX+1:2];
  assign req_tag = MCACHE_ADR_SM[31:IDX+2];
  assign lat_idx = MEM_ADR[IDX+1:2];
  assign lat_tag = MEM_ADR[31:IDX+2];

  // Store wins when both LOAD and STORE are set.
  assign req_store = MCACHE_ADR_VALID_SM & MCACHE_STORE_SM;
  assign req_load  = MCACHE_ADR_VALID_SM & MCACHE_LOAD_SM & ~MCACHE_STORE_SM;
  assign req_hit   = MCACHE_ADR_VALID_SM & valid[req_idx] &
                     (tag_mem[req_idx] == req_tag);
  assign lat_hit   = valid[lat_idx] & (tag_mem[lat_idx] == lat_tag);

  assign fill_en  = (state == RD_WAIT) & MEM_ACK;
  assign merge_en = (state == WR_WAIT) & MEM_ACK & lat_hit;

  // Core-facing stall and load result, combinational from request and state.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    MCACHE_STALL_SM  = 1'b0;
    MCACHE_RESULT_SM = '0;
    case (state)
      IDLE: begin
        if (req_store) begin
          MCACHE_STALL_SM = 1'b1;
        end else if (req_load) begin
          if (req_hit) MCACHE_RESULT_SM = data_mem[req_idx];
          else         MCACHE_STALL_SM  = 1'b1;
        end
      end
      RD_WAIT, WR_WAIT: MCACHE_STALL_SM = 1'b1;
      default: ;
    endcase
  end

  // Byte-lane merge of the latched store into the currently cached word.
  always_comb begin
    merged = data_mem[lat_idx];
    for (int k = 0; k < 4; k++) begin
      if (MEM_BYT_SEL[k]) merged[8*k +: 8] = MEM_DATA_W[8*k +: 8];
    end
  end

  // Controller state and registered memory-bus request.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state       <= IDLE;
      MEM_ADR     <= '0;
      MEM_DATA_W  <= '0;
      MEM_BYT_SEL <= '0;
      MEM_READ    <= 1'b0;
      MEM_WRITE   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_store) begin
            MEM_ADR     <= {MCACHE_ADR_SM[31:2], 2'b00};
            MEM_DATA_W  <= MCACHE_DATA_SM;
            MEM_BYT_SEL <= byt_sel;
            MEM_WRITE   <= 1'b1;
            state       <= WR_WAIT;
          end else if (req_load && !req_hit) begin
            MEM_ADR  <= {MCACHE_ADR_SM[31:2], 2'b00};
            MEM_READ <= 1'b1;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (MEM_ACK) begin
            MEM_READ <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_WAIT: begin
          if (MEM_ACK) begin
            MEM_WRITE <= 1'b0;
            state     <= WR_DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[lat_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill on read ack, byte merge on a store hit.
  always_ff @(posedge clk) begin
    // NOTE: the arrays carry no reset; the valid bits alone make stale
    // contents unreachable, which keeps these as plain RAM.
    if (fill_en) begin
      data_mem[lat_idx] <= MEM_DATA_R;
      tag_mem[lat_idx]  <= lat_tag;
    end else if (merge_en) begin
      data_mem[lat_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: the driver pushes the expected completion of
// each request, a monitor pops and compares whenever a request completes
// (request present with STALL=0). A responder models the memory bus.
module tb_dcache;

  logic        clk;
  logic        reset_n;
  logic        adr_valid;
  logic        load;
  logic        store;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [3:0]  bsel;
  logic [31:0] result;
  logic        stall;
  logic [31:0] mem_adr;
  logic [31:0] mem_data_w;
  logic [3:0]  mem_byt_sel;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ack;
  logic [31:0] mem_data_r;

  dcache #(.LINES(16)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .MCACHE_ADR_VALID_SM (adr_valid),
    .MCACHE_LOAD_SM      (load),
    .MCACHE_STORE_SM     (store),
    .MCACHE_ADR_SM       (adr),
    .MCACHE_DATA_SM      (wdata),
    .byt_sel             (bsel),
    .MCACHE_RESULT_SM    (result),
    .MCACHE_STALL_SM     (stall),
    .MEM_ADR             (mem_adr),
    .MEM_DATA_W          (mem_data_w),
    .MEM_BYT_SEL         (mem_byt_sel),
    .MEM_READ            (mem_read),
    .MEM_WRITE           (mem_write),
    .MEM_ACK             (mem_ack),
    .MEM_DATA_R          (mem_data_r)
  );

  // kind: 0 = no memory access, 1 = read, 2 = write
  typedef struct {
    logic [31:0] res;
    int          stall_cycles;
    int          kind;
    logic [31:0] madr;
    logic [3:0]  mbs;
    logic [31:0] mdw;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  int          ack_delay;
  logic [31:0] rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Memory responder: acks ack_delay cycles after a request first appears.
  initial begin
    mem_ack    = 1'b0;
    mem_data_r = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_read || mem_write) begin
        for (int i = 1; i < ack_delay; i++) begin
          @(posedge clk); #1;
          if (!reset_n) break;
        end
        if (reset_n && (mem_read || mem_write)) begin
          mem_ack    = 1'b1;
          mem_data_r = rd_data;
        end
      end
    end
  end

  // Monitor: counts stall cycles, records memory traffic, scores completions.
  initial begin
    int          stall_cnt;
    logic        saw_rd;
    logic        saw_wr;
    logic [31:0] obs_adr;
    logic [3:0]  obs_bs;
    logic [31:0] obs_dw;
    exp_t        e;
    stall_cnt = 0; saw_rd = 0; saw_wr = 0; obs_adr = '0; obs_bs = '0; obs_dw = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_cnt = 0; saw_rd = 0; saw_wr = 0;
      end else begin
        checks++;
        if (mem_read && mem_write) begin
          failures++;
          $display("FAIL mem_excl: MEM_READ and MEM_WRITE both 1");
        end
        if (adr_valid && (load || store)) begin
          if (stall) begin
            stall_cnt++;
            if (mem_read)  begin saw_rd = 1; obs_adr = mem_adr; end
            if (mem_write) begin saw_wr = 1; obs_adr = mem_adr; obs_bs = mem_byt_sel; obs_dw = mem_data_w; end
          end else begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_completion: adr 0x%08h with empty scoreboard", adr);
            end else begin
              e = exp_q.pop_front();
              check("result", result, e.res);
              check("stall_cycles", stall_cnt, e.stall_cycles);
              check("mem_read_seen", {31'b0, saw_rd}, {31'b0, e.kind == 1});
              check("mem_write_seen", {31'b0, saw_wr}, {31'b0, e.kind == 2});
              if (e.kind != 0) check("mem_adr", obs_adr, e.madr);
              if (e.kind == 2) begin
                check("mem_byt_sel", {28'b0, obs_bs}, {28'b0, e.mbs});
                check("mem_data_w", obs_dw, e.mdw);
              end
            end
            stall_cnt = 0; saw_rd = 0; saw_wr = 0;
          end
        end
      end
    end
  end

  // Present one request, push its expected completion, wait for it to finish.
  // Returns just after the following rising edge with the request still driven.
  task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] bs, input int dly,
                       input logic [31:0] rdat, input logic [31:0] e_res,
                       input int e_stall, input int e_kind, input logic [31:0] e_adr);
    exp_t e;
    bit   done;
    e.res = e_res; e.stall_cycles = e_stall; e.kind = e_kind;
    e.madr = e_adr; e.mbs = bs; e.mdw = d;
    exp_q.push_back(e);
    ack_delay = dly;
    rd_data   = rdat;
    adr_valid = 1'b1; load = ld; store = st; adr = a; wdata = d; bsel = bs;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) begin done = 1; break; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout: request to 0x%08h never completed", a);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    adr_valid = 1'b0; load = 1'b0; store = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; ack_delay = 1; rd_data = '0;
    reset_n = 1'b0; adr_valid = 1'b0; load = 1'b0; store = 1'b0;
    adr = '0; wdata = '0; bsel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_mem_adr", mem_adr, 32'h0);
    check("rst_mem_data_w", mem_data_w, 32'h0);
    check("rst_mem_byt_sel", {28'b0, mem_byt_sel}, 32'h0);
    check("rst_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    reset_n = 1'b1;
    idle(2);

    // Cold miss, ack three cycles after the request: four stall cycles.
    issue(1, 0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4, 1, 32'h100);
    // Hits, back to back, including a non-zero byte offset.
    issue(1, 0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0);
    issue(1, 0, 32'h103, 32'h0, 4'h0, 1, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0);
    // Conflict miss on index 0, then the evicted address misses again.
    issue(1, 0, 32'h140, 32'h0, 4'h0, 1, 32'h55667788, 32'h55667788, 2, 1, 32'h140);
    issue(1, 0, 32'h100, 32'h0, 4'h0, 2, 32'h11223344, 32'h11223344, 3, 1, 32'h100);
    // Store hit with partial byte enables, then back-to-back hits see the merge.
    issue(0, 1, 32'h100, 32'hAABBCCDD, 4'b0101, 1, 32'h0, 32'h0, 2, 2, 32'h100);
    issue(1, 0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 32'h11BB33DD, 0, 0, 32'h0);
    issue(1, 0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 32'h11BB33DD, 0, 0, 32'h0);
    idle(1);
    // Store miss: written through, nothing allocated; a load of it then misses.
    issue(0, 1, 32'h202, 32'h12345678, 4'b1111, 2, 32'h0, 32'h0, 3, 2, 32'h200);
    issue(1, 0, 32'h200, 32'h0, 4'h0, 1, 32'h12345678, 32'h12345678, 2, 1, 32'h200);
    // LOAD and STORE together: store path, merged into the hitting line.
    issue(1, 1, 32'h200, 32'hCAFEF00D, 4'b1100, 1, 32'h0, 32'h0, 2, 2, 32'h200);
    issue(1, 0, 32'h200, 32'h0, 4'h0, 1, 32'h0, 32'hCAFE5678, 0, 0, 32'h0);
    idle(2);

    // Reset during RD_WAIT: request drops at once, fill is discarded.
    ack_delay = 5; rd_data = 32'h99999999;
    adr_valid = 1'b1; load = 1'b1; store = 1'b0; adr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rdwait_mem_read", {31'b0, mem_read}, 32'h1);
    check("rdwait_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    reset_n = 1'b0; adr_valid = 1'b0; load = 1'b0;
    #1;
    check("rst_mid_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mid_mem_write", {31'b0, mem_write}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);
    // Valid bits were cleared: both the old line and the aborted address miss.
    issue(1, 0, 32'h200, 32'h0, 4'h0, 1, 32'hCAFE5678, 32'hCAFE5678, 2, 1, 32'h200);
    issue(1, 0, 32'h300, 32'h0, 4'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 2, 1, 32'h300);
    issue(1, 0, 32'h300, 32'h0, 4'h0, 1, 32'h0, 32'h0BADF00D, 0, 0, 32'h0);
    idle(3);

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache that answers the core's Mcache port on one side and drives a single-word memory bus on the other. Loads that hit complete with no stall. Load misses fetch one word from memory. Stores are written through to memory and merged into the cache when they hit. It sits between the core's memory stage and the external data memory.

## Interface
- LINES, 16: number of one-word lines; power of two, at least 2. IDX = log2(LINES).
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- MCACHE_ADR_VALID_SM  in  1  core request valid.
- MCACHE_LOAD_SM  in  1  request is a load.
- MCACHE_STORE_SM  in  1  request is a store.
- MCACHE_ADR_SM  in  32  byte address.
- MCACHE_DATA_SM  in  32  store data, already lane-aligned.
- byt_sel  in  4  store byte enables; bit k enables bits [8k+7:8k].
- MCACHE_RESULT_SM  out  32  load data, full aligned word.
- MCACHE_STALL_SM  out  1  core must hold its request unchanged while this is 1.
- MEM_ADR  out  32  word address to memory; bits [1:0] are 0.
- MEM_DATA_W  out  32  store data.
- MEM_BYT_SEL  out  4  store byte enables.
- MEM_READ  out  1  read request; held until MEM_ACK.
- MEM_WRITE  out  1  write request; held until MEM_ACK.
- MEM_ACK  in  1  memory completes the current request this cycle.
- MEM_DATA_R  in  32  read data, valid when MEM_ACK=1.

## Operation
- Address split: index = ADR[IDX+1:2], tag = ADR[31:IDX+2]. ADR[1:0] is ignored for lookup and forced to 0 on MEM_ADR.
- Per-line storage: valid bit, tag, 32-bit data. Reset clears all valid bits. Tag and data arrays are not reset.
- hit = ADR_VALID & valid[index] & (tag matches).
- A request needs ADR_VALID=1 plus LOAD or STORE. If both are set, STORE has priority. ADR_VALID with neither set is a no-op with STALL=0.
- FSM states:
  - IDLE
    - Load hit: RESULT = data[index], STALL=0, stay in IDLE.
    - Load miss: STALL=1, latch the word address, go to RD_WAIT.
    - Store: STALL=1, latch address, data and byt_sel, go to WR_WAIT.
    - Otherwise: STALL=0.
  - RD_WAIT
    - MEM_READ=1, STALL=1.
    - On MEM_ACK: write MEM_DATA_R into the line, set valid, write the tag, go to IDLE. The held load then hits.
  - WR_WAIT
    - MEM_WRITE=1, STALL=1.
    - On MEM_ACK: if the latched address hits, merge the bytes selected by byt_sel into the line. Go to WR_DONE.
    - A store miss allocates nothing.
  - WR_DONE
    - STALL=0 for exactly one cycle. This is the completion cycle of the held store; no memory request is issued.
    - Next state is IDLE. A new request presented in this cycle is not evaluated; it is handled from IDLE on the next cycle.
- MEM_ACK is ignored in IDLE and WR_DONE.
- MEM_* outputs come from registers. MEM_READ and MEM_WRITE are never both 1.
- RESULT is 0 when the request is not a hitting load.
- Reset asserted mid-transaction: FSM returns to IDLE, MEM_READ/MEM_WRITE drop at once, the in-flight fill is discarded, and all valid bits are cleared.

## Timing
- Reset values: MCACHE_RESULT_SM=0, MCACHE_STALL_SM=0, MEM_ADR=0, MEM_DATA_W=0, MEM_BYT_SEL=0, MEM_READ=0, MEM_WRITE=0.
- STALL and RESULT are combinational from the request and the current state.
- Load hit: 0-cycle latency; data is in the same cycle as the request.
- Load miss: request in cycle N. MEM_READ is 1 from N+1 until the ack cycle M. STALL=0 with data at cycle M+1. Minimum stall is 2 cycles (ack at N+1).
- Store: request in cycle N. MEM_WRITE is 1 from N+1 until the ack cycle M. STALL=0 at M+1 (WR_DONE). Minimum stall is 2 cycles.
- Load to the same index right after a store hit sees the merged data.
- Back-to-back loads that hit: one per cycle.

## Test plan
- Reset, then load 0x100 with MEM_DATA_R=0xDEADBEEF and ack 3 cycles later -> STALL=1 for 4 cycles, MEM_ADR=0x100, RESULT=0xDEADBEEF. A second load of 0x100 returns it with STALL=0.
- Load 0x140 (same index as 0x100, LINES=16) -> miss and refill. A reload of 0x100 misses again.
- Cached word 0x11223344 at 0x100; store 0xAABBCCDD with byt_sel=0b0101 -> MEM_WRITE with MEM_BYT_SEL=0101, one WR_DONE cycle. Reload of 0x100 hits with 0x11BB33DD.
- Store to an uncached address 0x200 -> memory write issued. A following load of 0x200 misses (no allocate).
- Assert reset_n=0 during RD_WAIT, release, reload the same address -> MEM_READ drops immediately and the load misses again.
- LOAD and STORE both 1 -> store path taken: MEM_WRITE=1, MEM_READ stays 0.
